// File: rtl/sram_adapter_pkg.sv
// Shared types and constants for the SRAM request adapter.
package sram_adapter_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

  localparam int WORD_BYTES = 4;

  // Width of the byte-address bits above the word index that select the window.
  function automatic int tag_width(input int addr_width);
    return 32 - addr_width - 2;
  endfunction

endpackage

// File: rtl/sram_req_adapter_if.sv
// Core request/response bus plus SRAM macro controls for the adapter.
// valid/ready: a beat transfers on a rising clock edge where valid and ready are both 1;
// the sender holds valid and payload stable until then, and ready never depends on valid.
interface sram_req_adapter_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [31:0]           req_addr_i;
  logic                  req_we_i;
  logic [3:0]            req_be_i;
  logic [31:0]           req_wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [31:0]           rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  sram_csb_o;
  logic                  sram_web_o;
  logic [3:0]            sram_wmask_o;
  logic [ADDR_WIDTH-1:0] sram_addr_o;
  logic [31:0]           sram_wdata_o;
  logic [31:0]           sram_rdata_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i, rsp_ready_i, sram_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output sram_csb_o, sram_web_o, sram_wmask_o, sram_addr_o, sram_wdata_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i, rsp_ready_i, sram_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  sram_csb_o, sram_web_o, sram_wmask_o, sram_addr_o, sram_wdata_o
  );

endinterface

// File: rtl/sram_req_adapter.sv
// Single-outstanding load/store front-end for a single-port SRAM macro with a
// fixed read latency; out-of-window accesses are answered with an error only.
module sram_req_adapter
  import sram_adapter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 13,
  parameter int          READ_LAT   = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  sram_req_adapter_if.slave   bus,
  output state_e              state_o
);

  localparam int          TAG_W    = tag_width(ADDR_WIDTH);
  localparam logic [2:0]  LAT_INIT = 3'(READ_LAT - 1);

  state_e                state_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [31:0]           rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  csb_q;
  logic                  web_q;
  logic                  we_q;
  logic [3:0]            wmask_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [2:0]            cnt_q;

  logic                  in_range;
  logic                  unused_addr_lsb;

  assign in_range        = (bus.req_addr_i[31:32-TAG_W] == BASE_ADDR[31:32-TAG_W]);
  assign unused_addr_lsb = ^bus.req_addr_i[1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      we_q        <= 1'b0;
      wmask_q     <= 4'h0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      cnt_q       <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid_i && req_ready_q) begin
            req_ready_q <= 1'b0;
            if (in_range) begin
              state_q <= ACCESS;
              csb_q   <= 1'b0;
              web_q   <= ~bus.req_we_i;
              we_q    <= bus.req_we_i;
              wmask_q <= bus.req_we_i ? bus.req_be_i : 4'h0;
              addr_q  <= bus.req_addr_i[ADDR_WIDTH+1:2];
              wdata_q <= bus.req_wdata_i;
            end else begin
              // The SRAM is never touched for a miss; answer straight away.
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'h0;
            end
          end
        end
        ACCESS: begin
          csb_q <= 1'b1;
          web_q <= 1'b1;
          if (we_q) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
          end else begin
            state_q <= WAIT;
            cnt_q   <= LAT_INIT;
          end
        end
        WAIT: begin
          if (cnt_q == 3'd0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= bus.sram_rdata_i;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o  = req_ready_q;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_rdata_o  = rsp_rdata_q;
  assign bus.rsp_err_o    = rsp_err_q;
  assign bus.sram_csb_o   = csb_q;
  assign bus.sram_web_o   = web_q;
  assign bus.sram_wmask_o = wmask_q;
  assign bus.sram_addr_o  = addr_q;
  assign bus.sram_wdata_o = wdata_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_sram_req_adapter.sv
// Randomized bench for sram_req_adapter: word-array reference model, behavioural
// SRAM with real read latency, and a response scoreboard fed by the driver.
`timescale 1ns/1ps
module tb_sram_req_adapter;
  import sram_adapter_pkg::*;

  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam int          AW        = 13;
  localparam int          RL        = 3;
  localparam int          WORDS     = 1 << AW;
  localparam logic [31:0] WIN_BYTES = 32'(WORD_BYTES * WORDS);

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          hs_cyc;
  } rsp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          web;
    logic [3:0]    wmask;
    logic [31:0]   wdata;
  } acc_t;

  logic   clk;
  logic   rst;
  state_e dbg_state;
  int     cyc = 0;
  int     tests = 0;
  int     fails = 0;
  int     bp_mode = 0;      // 0 random rsp_ready, 1 hold low, 2 hold high
  bit     in_rsp = 0;
  logic [31:0] held_rdata;
  logic        held_err;

  rsp_t exp_q[$];
  acc_t acc_q[$];
  logic [31:0] ref_mem [WORDS];
  logic [31:0] sram    [WORDS];

  bit          rd_pending = 0;
  int          rd_due;
  logic [31:0] rd_data;
  int          sm_edge;

  sram_req_adapter_if #(.ADDR_WIDTH(AW)) bus ();

  sram_req_adapter #(.BASE_ADDR(BASE), .ADDR_WIDTH(AW), .READ_LAT(RL)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus),
    .state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural SRAM ----------------
  always @(posedge clk) begin
    sm_edge = cyc;
    if (bus.sram_csb_o === 1'b0) begin
      if (acc_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sram_unexpected_access: csb low at addr %h, required no access", bus.sram_addr_o);
      end else begin
        check("sram_addr",  32'(bus.sram_addr_o),  32'(acc_q[0].addr));
        check("sram_web",   32'(bus.sram_web_o),   32'(acc_q[0].web));
        check("sram_wmask", 32'(bus.sram_wmask_o), 32'(acc_q[0].wmask));
        check("sram_wdata", bus.sram_wdata_o,      acc_q[0].wdata);
        void'(acc_q.pop_front());
      end
      if (bus.sram_web_o === 1'b0) begin
        for (int b = 0; b < 4; b++)
          if (bus.sram_wmask_o[b]) sram[bus.sram_addr_o][8*b +: 8] = bus.sram_wdata_o[8*b +: 8];
      end else begin
        rd_pending = 1'b1;
        rd_due     = sm_edge + RL - 1;
        rd_data    = sram[bus.sram_addr_o];
      end
    end
    #1;
    if (rd_pending && sm_edge == rd_due) begin
      bus.sram_rdata_i = rd_data;
      rd_pending       = 1'b0;
    end else begin
      bus.sram_rdata_i = $urandom;
    end
  end

  // ---------------- response backpressure ----------------
  always @(posedge clk) begin
    #1;
    if (bp_mode == 1)      bus.rsp_ready_i = 1'b0;
    else if (bp_mode == 2) bus.rsp_ready_i = 1'b1;
    else                   bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_spurious: rsp_valid_o=1 with rdata %h, required no response", bus.rsp_rdata_o);
      end else begin
        check("req_ready_during_rsp", 32'(bus.req_ready_o), 32'd0);
        if (!in_rsp) begin
          in_rsp     = 1'b1;
          held_rdata = bus.rsp_rdata_o;
          held_err   = bus.rsp_err_o;
          check("rsp_latency", 32'(cyc - exp_q[0].hs_cyc), 32'(exp_q[0].lat));
        end else begin
          check("rsp_rdata_stable", bus.rsp_rdata_o,     held_rdata);
          check("rsp_err_stable",   32'(bus.rsp_err_o),  32'(held_err));
        end
        if (bus.rsp_ready_i === 1'b1) begin
          check("rsp_rdata", bus.rsp_rdata_o,    exp_q[0].rdata);
          check("rsp_err",   32'(bus.rsp_err_o), 32'(exp_q[0].err));
          void'(exp_q.pop_front());
          in_rsp = 1'b0;
        end
      end
    end
  end

  // ---------------- driver with reference model ----------------
  task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wdata);
    rsp_t        e;
    acc_t        a;
    int          n;
    int          widx;
    logic [31:0] off;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    bus.req_we_i    = we;
    bus.req_be_i    = be;
    bus.req_wdata_i = wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.req_ready_o !== 1'b1 && n < 100);
    if (bus.req_ready_o !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL req_handshake: req_ready_o=%b after %0d cycles, required 1", bus.req_ready_o, n);
    end else begin
      off      = addr - BASE;
      widx     = int'(off >> 2);
      e.hs_cyc = cyc;
      if (off >= WIN_BYTES) begin
        e.err   = 1'b1;
        e.rdata = 32'h0;
        e.lat   = 1;
      end else begin
        a.addr  = widx[AW-1:0];
        a.web   = ~we;
        a.wmask = we ? be : 4'h0;
        a.wdata = wdata;
        acc_q.push_back(a);
        e.err = 1'b0;
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[widx][8*b +: 8] = wdata[8*b +: 8];
          e.rdata = 32'h0;
          e.lat   = 2;
        end else begin
          e.rdata = ref_mem[widx];
          e.lat   = RL + 2;
        end
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = $urandom;
    bus.req_we_i    = 1'($urandom_range(0, 1));
    bus.req_be_i    = 4'($urandom_range(0, 15));
    bus.req_wdata_i = $urandom;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d responses outstanding after %0d cycles, required 0", exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] v;
    int          n;
    rst             = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = 32'h0;
    bus.req_we_i    = 1'b0;
    bus.req_be_i    = 4'h0;
    bus.req_wdata_i = 32'h0;
    for (int i = 0; i < WORDS; i++) begin
      v          = $urandom;
      sram[i]    = v;
      ref_mem[i] = v;
    end
    #23;
    check("reset_req_ready", 32'(bus.req_ready_o),  32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid_o),  32'd0);
    check("reset_rsp_rdata", bus.rsp_rdata_o,       32'h0);
    check("reset_rsp_err",   32'(bus.rsp_err_o),    32'd0);
    check("reset_csb",       32'(bus.sram_csb_o),   32'd1);
    check("reset_web",       32'(bus.sram_web_o),   32'd1);
    check("reset_wmask",     32'(bus.sram_wmask_o), 32'd0);
    check("reset_addr",      32'(bus.sram_addr_o),  32'd0);
    check("reset_wdata",     bus.sram_wdata_o,      32'h0);
    check("reset_state",     32'(dbg_state),        32'(IDLE));
    @(negedge clk);
    rst = 1'b0;

    // directed: store/load, partial store, window edges, empty mask, misalignment
    issue(32'h0000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF);
    issue(32'h0000_0010, 1'b0, 4'h0, 32'h1234_5678);
    issue(32'h0000_0010, 1'b1, 4'h3, 32'h0000_AA55);
    issue(32'h0000_0010, 1'b0, 4'h0, 32'h0);
    issue(32'h0000_8000, 1'b0, 4'h0, 32'h0);
    issue(32'h0000_7FFC, 1'b0, 4'h0, 32'h0);
    issue(32'h0000_7FFC, 1'b1, 4'hA, 32'h5A5A_C3C3);
    issue(32'h0000_7FFE, 1'b0, 4'h0, 32'h0);
    issue(32'h0000_0020, 1'b1, 4'h0, 32'hFFFF_FFFF);
    issue(32'h0000_0023, 1'b0, 4'h0, 32'h0);
    issue(32'hFFFF_FFFC, 1'b1, 4'hF, 32'h0BAD_0BAD);
    wait_idle(100);

    // backpressure: hold the load response for 5 cycles, then release
    bp_mode = 1;
    issue(32'h0000_0010, 1'b0, 4'h0, 32'h0);
    n = 0;
    while (bus.rsp_valid_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_rsp_valid_seen", 32'(bus.rsp_valid_o), 32'd1);
    repeat (5) @(negedge clk);
    check("bp_rsp_valid_held", 32'(bus.rsp_valid_o), 32'd1);
    bp_mode = 2;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.rsp_valid_o === 1'b1 && bus.rsp_ready_i === 1'b1) && n < 10);
    @(negedge clk);
    check("bp_rsp_valid_dropped", 32'(bus.rsp_valid_o), 32'd0);
    check("bp_next_req_ready",    32'(bus.req_ready_o), 32'd1);
    bp_mode = 0;
    issue(32'h0000_0014, 1'b1, 4'hC, 32'hCAFE_F00D);
    issue(32'h0000_0014, 1'b0, 4'h0, 32'h0);
    wait_idle(100);

    // randomized traffic over both ends of the window plus misses
    for (int t = 0; t < 150; t++) begin
      int          w;
      logic [31:0] addr;
      if ($urandom_range(0, 9) == 0) begin
        addr = BASE + WIN_BYTES + 32'($urandom_range(0, 4095));
      end else begin
        w    = $urandom_range(0, 15);
        w    = (w < 8) ? w : WORDS - 16 + w;
        addr = BASE + 32'(w * 4) + 32'($urandom_range(0, 3));
      end
      issue(addr, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
    end
    wait_idle(200);

    // asynchronous reset while a load waits on SRAM data
    issue(32'h0000_0018, 1'b0, 4'h0, 32'h0);
    n = 0;
    while (dbg_state != WAIT && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_wait", 32'(dbg_state), 32'(WAIT));
    #2;
    rst = 1'b1;
    #1;
    check("rst_csb",       32'(bus.sram_csb_o),  32'd1);
    check("rst_web",       32'(bus.sram_web_o),  32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
    check("rst_state",     32'(dbg_state),       32'(IDLE));
    exp_q.delete();
    in_rsp = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    issue(32'h0000_0018, 1'b0, 4'h0, 32'h0);
    issue(32'h0000_0010, 1'b0, 4'h0, 32'h0);
    wait_idle(100);

    tests++;
    if (acc_q.size() != 0) begin
      fails++;
      $display("FAIL sram_access_count: %0d expected SRAM cycles never seen, required 0", acc_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_req_adapter.md
Name: sram_req_adapter

Overview:
- Upstream front-end for the 8K x 32 single-port SRAM macro wrapper.
- Converts a core-side valid/ready byte-addressed load/store request into the SRAM chip-select, write-enable, mask and word-address controls.
- Waits the SRAM read latency, captures read data, and returns a valid/ready response.
- Decodes an address window and flags out-of-range accesses.
- One transaction is outstanding at a time.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte base of the SRAM window; aligned to 4*2^ADDR_WIDTH.
- ADDR_WIDTH, 13: SRAM word-address width; window size is 4*2^ADDR_WIDTH bytes.
- READ_LAT, 1: cycles from the ACCESS cycle until sram_rdata_i is valid; legal range 1..7.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  adapter can accept a request
- req_addr_i  in  32  byte address
- req_we_i  in  1  1=store, 0=load
- req_be_i  in  4  byte enables for stores
- req_wdata_i  in  32  store data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  core accepts response
- rsp_rdata_o  out  32  load data; 0 for stores and errors
- rsp_err_o  out  1  access outside window
- sram_csb_o  out  1  SRAM chip select, active-low
- sram_web_o  out  1  SRAM write enable, active-low (1=read)
- sram_wmask_o  out  4  SRAM byte write mask
- sram_addr_o  out  ADDR_WIDTH  SRAM word address
- sram_wdata_o  out  32  SRAM write data
- sram_rdata_i  in  32  SRAM read data

Behaviour:
- Reset values (asynchronous): state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, sram_csb_o=1, sram_web_o=1, sram_wmask_o=0, sram_addr_o=0, sram_wdata_o=0, latency counter 0.
- All SRAM outputs are registered. The request is captured on req_valid_i && req_ready_o.
- req_ready_o=1 only in IDLE.
- State IDLE:
  - On handshake with an in-range address (req_addr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]), go to ACCESS.
  - Register sram_addr_o=req_addr_i[ADDR_WIDTH+1:2] and sram_web_o=~req_we_i.
  - Register sram_wmask_o=req_be_i for stores, 4'h0 for loads.
  - Register sram_wdata_o=req_wdata_i.
  - Register sram_csb_o=0 for exactly the ACCESS cycle.
  - Out-of-range: no SRAM access (csb stays 1); go directly to RESP with rsp_err_o=1 and rsp_rdata_o=0.
- State ACCESS (1 cycle):
  - Next cycle csb=1 and web=1.
  - Store: go to RESP with rdata=0, err=0.
  - Load: load counter with READ_LAT-1. If READ_LAT==1, capture sram_rdata_i at the end of the first WAIT cycle.
- State WAIT:
  - Decrement the counter each cycle.
  - When counter==0, latch sram_rdata_i into rsp_rdata_o, set err=0, go to RESP.
- State RESP:
  - rsp_valid_o=1; data and err are held stable until rsp_ready_i.
  - On rsp_ready_i, go to IDLE and clear rsp_valid_o. The next request can be accepted in that IDLE cycle.
- Latency from request handshake to rsp_valid_o:
  - Store: 2 cycles.
  - Load: READ_LAT+2 cycles.
  - Error: 1 cycle.
- Request bits and the response are not combinationally dependent on each other: no path from req to rsp, and none from rsp_ready_i to req_ready_o.
- Edge cases:
  - Store with req_be_i=0: SRAM cycle is still issued (no bytes written); normal response.
  - Misaligned addr[1:0] is ignored; the word index is used.
  - Address at the window top (BASE+4*2^ADDR_WIDTH-4) is in range; BASE+4*2^ADDR_WIDTH is an error.
- Reset mid-transaction: aborts immediately to the reset values. No response is issued for the in-flight request; the SRAM write may or may not have occurred.

Decomposition:
- Package sram_adapter_pkg:
  - typedef enum logic [1:0] state_e {IDLE, ACCESS, WAIT, RESP}
  - constant WORD_BYTES=4
  - localparam helper for the window tag width (32-ADDR_WIDTH-2)
- No sub-module. The latency counter and address decode are inline.

Test Plan:
- Store then load: store addr=0x0000_0010, be=0xF, wdata=0xDEADBEEF.
  - SRAM cycle: csb=0, web=0, addr=0x004, wmask=0xF.
  - rsp 2 cycles after handshake, err=0.
  - Then a load from the same address returns 0xDEADBEEF at READ_LAT+2 cycles.
- Partial store: be=0x3, wdata=0x0000_AA55 to a word holding 0xDEADBEEF -> wmask=0x3; a later load returns 0xDEADAA55.
- Out-of-range: load addr=0x0000_8000 (BASE=0, ADDR_WIDTH=13) -> csb never low; rsp after 1 cycle with err=1, rdata=0. Addr 0x0000_7FFC is in range, word 0x1FFF.
- Backpressure: hold rsp_ready_i=0 for 5 cycles during a load response -> rsp_valid_o and rdata held stable, req_ready_o=0. Release -> rsp_valid_o drops, and a back-to-back request is accepted the next cycle.
- READ_LAT=3: load -> rdata captured exactly 3 cycles after ACCESS; rsp at 5 cycles after handshake.
- Reset mid-WAIT: assert rst_i asynchronously -> csb=1, web=1, rsp_valid_o=0, and req_ready_o=1 immediately; no spurious response after release.
